// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 slave definitions.
// Holds the memory arbiter state encoding and its default sizing constants.
package axi4_globals_pkg;

  localparam int unsigned ARB_LEN_W          = 8;
  localparam int unsigned ARB_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_WR = 2'd1,
    GNT_RD = 2'd2
  } axi4_arb_state_e;

endpackage

// File: rtl/axi4_slave_mem_arbiter.sv
// Burst-granular round-robin arbiter sharing the slave memory port between the
// write-data engine and the read-data engine. A grant covers a whole burst of
// len+1 beats. On the final beat it hands the port straight to the next
// requester, with no idle cycle in between.
//
// Optional feature macro: AXI4_ARB_TIMEOUT_EN. When it is defined, a stall
// watchdog aborts a burst after TIMEOUT_CYCLES granted cycles pass with no
// beat.
//
// Ports:
//   aclk, areset             clock, synchronous active-high reset
//   wr_req, wr_len, wr_gnt   write engine request / burst length / grant
//   rd_req, rd_len, rd_gnt   read engine request / burst length / grant
//   mem_en, mem_sel          port active, owner select (0 = write, 1 = read)
//   mem_beat_done            memory accepted one beat this cycle
//   beat_cnt, last_beat      beats completed in this burst, final-beat flag
//   timeout_err              one-cycle stall-abort pulse (optional feature)
module axi4_slave_mem_arbiter
  import axi4_globals_pkg::*;
#(
  parameter int unsigned LEN_W          = ARB_LEN_W,
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             wr_req,
  input  logic [LEN_W-1:0] wr_len,
  output logic             wr_gnt,
  input  logic             rd_req,
  input  logic [LEN_W-1:0] rd_len,
  output logic             rd_gnt,
  output logic             mem_en,
  output logic             mem_sel,
  input  logic             mem_beat_done,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             last_beat,
  output logic             timeout_err
);

  axi4_arb_state_e  state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_d;
  logic             ptr_q, ptr_d;   // 1 = read engine served last
  logic             sel_d;
  logic             grant_wr, grant_rd;
  logic             tmo_d;

`ifdef AXI4_ARB_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
`else
  wire unused_timeout_cycles = |32'(TIMEOUT_CYCLES);
`endif

  // Next-state, burst bookkeeping and output values.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = beat_cnt;
    ptr_d    = ptr_q;
    sel_d    = mem_sel;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    tmo_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On a tie, the engine that was not served last wins.
        if (wr_req && (!rd_req || ptr_q)) grant_wr = 1'b1;
        else if (rd_req)                  grant_rd = 1'b1;
      end
      GNT_WR: begin
        if (mem_beat_done) begin
          if (beat_cnt == len_q) begin
            ptr_d = 1'b0;
            if (rd_req)      grant_rd = 1'b1;
            else if (wr_req) grant_wr = 1'b1;
            else             state_d  = IDLE;
          end else begin
            cnt_d = beat_cnt + LEN_W'(1);
          end
        end
      end
      GNT_RD: begin
        if (mem_beat_done) begin
          if (beat_cnt == len_q) begin
            ptr_d = 1'b1;
            if (wr_req)      grant_wr = 1'b1;
            else if (rd_req) grant_rd = 1'b1;
            else             state_d  = IDLE;
          end else begin
            cnt_d = beat_cnt + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef AXI4_ARB_TIMEOUT_EN
    // Stall watchdog: a stall only exists when no beat arrives, so no
    // handoff can be pending in the same cycle as an abort.
    stall_d = '0;
    if (state_q != IDLE && !mem_beat_done) begin
      if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
        tmo_d   = 1'b1;
        state_d = IDLE;
        ptr_d   = (state_q == GNT_RD);
      end else begin
        stall_d = stall_q + STALL_W'(1);
      end
    end
`endif

    if (grant_wr) begin
      state_d = GNT_WR;
      len_d   = wr_len;
      cnt_d   = '0;
      sel_d   = 1'b0;
    end else if (grant_rd) begin
      state_d = GNT_RD;
      len_d   = rd_len;
      cnt_d   = '0;
      sel_d   = 1'b1;
    end

`ifdef AXI4_ARB_TIMEOUT_EN
    if (grant_wr || grant_rd) stall_d = '0;
`endif
  end

  // State and registered outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      ptr_q     <= 1'b1;
      wr_gnt    <= 1'b0;
      rd_gnt    <= 1'b0;
      mem_en    <= 1'b0;
      mem_sel   <= 1'b0;
      beat_cnt  <= '0;
      last_beat <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      ptr_q     <= ptr_d;
      wr_gnt    <= (state_d == GNT_WR);
      rd_gnt    <= (state_d == GNT_RD);
      mem_en    <= (state_d != IDLE);
      mem_sel   <= sel_d;
      beat_cnt  <= cnt_d;
      last_beat <= (state_d != IDLE) && (cnt_d == len_d);
    end
  end

`ifdef AXI4_ARB_TIMEOUT_EN
  // Stall counter and abort pulse.
  always_ff @(posedge aclk) begin
    if (areset) begin
      stall_q     <= '0;
      timeout_err <= 1'b0;
    end else begin
      stall_q     <= stall_d;
      timeout_err <= tmo_d;
    end
  end
`else
  assign timeout_err = 1'b0;
  wire unused_tmo = tmo_d;
`endif

endmodule
